// File: rtl/vid_ddr_pkg.sv
// Shared types and helpers for the video DDR write-burst path.
package vid_ddr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2,
        B    = 2'd3
    } wr_state_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    function automatic int unsigned clog2(input longint unsigned v);
        int unsigned r;
        r = 32'd0;
        while ((64'd1 << r) < v) begin
            r = r + 32'd1;
        end
        return r;
    endfunction

    function automatic int unsigned calc_bpb(input int unsigned dw);
        return dw / 32'd8;
    endfunction

    localparam int unsigned DEF_DATA_WIDTH = 32'd256;
    localparam int unsigned DEF_BPB        = calc_bpb(DEF_DATA_WIDTH);

endpackage

// File: rtl/vid_buf_addr_gen.sv
// Frame-buffer ring bookkeeping: current buffer, next burst address and beats left in the frame.
module vid_buf_addr_gen
    import vid_ddr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 256,
    parameter int unsigned ADDR_WIDTH  = 28,
    parameter int unsigned BURST_LEN   = 16,
    parameter int unsigned FRAME_BEATS = 129600,
    parameter int unsigned NUM_BUF     = 3,
    parameter int unsigned BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned BUF_STRIDE  = 32'h0100_0000,
    localparam int unsigned BPB        = calc_bpb(DATA_WIDTH),
    localparam int unsigned RW         = clog2(64'(FRAME_BEATS) + 64'd1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  advance_i,
    input  logic                  burst_done_i,
    input  logic [8:0]            burst_beats_i,
    output logic [2:0]            cur_buf_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [RW-1:0]         remain_o,
    output logic [7:0]            next_len_o
);

    logic [2:0]            cur_buf_q, cur_buf_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [RW-1:0]         remain_q, remain_d;
    logic [2:0]            next_buf_s;
    logic [2:0]            load_buf_s;
    logic [ADDR_WIDTH-1:0] step_s;
    logic [7:0]            next_len_s;

    // Next-state for buffer index, address and remaining beats; a load targets the advanced buffer when both fire.
    always_comb begin
        cur_buf_d = cur_buf_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        if (cur_buf_q == 3'(NUM_BUF - 32'd1)) begin
            next_buf_s = 3'd0;
        end else begin
            next_buf_s = cur_buf_q + 3'd1;
        end
        if (advance_i) begin
            load_buf_s = next_buf_s;
            cur_buf_d  = next_buf_s;
        end else begin
            load_buf_s = cur_buf_q;
            cur_buf_d  = cur_buf_q;
        end
        step_s = ADDR_WIDTH'(32'(burst_beats_i) * BPB);
        if (load_i) begin
            addr_d   = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(load_buf_s) * ADDR_WIDTH'(BUF_STRIDE);
            remain_d = RW'(FRAME_BEATS);
        end else if (burst_done_i) begin
            addr_d   = addr_q + step_s;
            remain_d = remain_q - RW'(burst_beats_i);
        end else begin
            addr_d   = addr_q;
            remain_d = remain_q;
        end
        if (32'(remain_q) >= BURST_LEN) begin
            next_len_s = 8'(BURST_LEN - 32'd1);
        end else if (remain_q != {RW{1'b0}}) begin
            next_len_s = 8'(32'(remain_q) - 32'd1);
        end else begin
            next_len_s = 8'd0;
        end
    end

    // Ring state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_buf_q <= 3'd0;
            addr_q    <= {ADDR_WIDTH{1'b0}};
            remain_q  <= {RW{1'b0}};
        end else begin
            cur_buf_q <= cur_buf_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
        end
    end

    assign cur_buf_o  = cur_buf_q;
    assign addr_o     = addr_q;
    assign remain_o   = remain_q;
    assign next_len_o = next_len_s;

endmodule

// File: rtl/vid_ddr_wr_burst.sv
// Pops 256-bit words from the prefetch FIFO and writes each frame into a DDR buffer ring as AXI4 INCR bursts.
module vid_ddr_wr_burst
    import vid_ddr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 256,
    parameter int unsigned ADDR_WIDTH  = 28,
    parameter int unsigned BURST_LEN   = 16,
    parameter int unsigned FRAME_BEATS = 129600,
    parameter int unsigned NUM_BUF     = 3,
    parameter int unsigned BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned BUF_STRIDE  = 32'h0100_0000,
    localparam int unsigned BPB        = calc_bpb(DATA_WIDTH),
    localparam int unsigned RW         = clog2(64'(FRAME_BEATS) + 64'd1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_vld,
    output logic                  fifo_rd_en,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [7:0]            awlen,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [BPB-1:0]        wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic                  frame_done,
    output logic [2:0]            cur_buf,
    output logic                  overrun,
    output logic                  bresp_err
);

    wr_state_e             state_q, state_d;
    logic                  active_q, active_d;
    logic                  start_pend_q, start_pend_d;
    logic                  awvalid_q, awvalid_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [7:0]            awlen_q, awlen_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic                  frame_done_q, frame_done_d;
    logic                  overrun_q, overrun_d;
    logic                  bresp_err_q, bresp_err_d;

    logic                  load_s, advance_s, burst_done_s;
    logic                  beat_s, pend_s, complete_s;
    logic [8:0]            burst_beats_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [RW-1:0]         remain_s;
    logic [7:0]            next_len_s;

    assign burst_beats_s = {1'b0, awlen_q} + 9'd1;

    vid_buf_addr_gen #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BURST_LEN   (BURST_LEN),
        .FRAME_BEATS (FRAME_BEATS),
        .NUM_BUF     (NUM_BUF),
        .BASE_ADDR   (BASE_ADDR),
        .BUF_STRIDE  (BUF_STRIDE)
    ) u_addr_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_i        (load_s),
        .advance_i     (advance_s),
        .burst_done_i  (burst_done_s),
        .burst_beats_i (burst_beats_s),
        .cur_buf_o     (cur_buf),
        .addr_o        (addr_s),
        .remain_o      (remain_s),
        .next_len_o    (next_len_s)
    );

    // Burst FSM next-state and control strobes.
    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        start_pend_d = start_pend_q;
        awvalid_d    = awvalid_q;
        awaddr_d     = awaddr_q;
        awlen_d      = awlen_q;
        beat_cnt_d   = beat_cnt_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        bresp_err_d  = bresp_err_q;
        load_s       = 1'b0;
        advance_s    = 1'b0;
        burst_done_s = 1'b0;
        beat_s       = (state_q == W) && fifo_rd_vld && wready;
        pend_s       = start_pend_q || frame_start;
        complete_s   = (32'(remain_s) == 32'(burst_beats_s));

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    // A start between bursts of an unfinished frame abandons it onto the next buffer.
                    load_s   = 1'b1;
                    active_d = 1'b1;
                    if (active_q && (remain_s != {RW{1'b0}})) begin
                        advance_s = 1'b1;
                        overrun_d = 1'b1;
                    end else begin
                        advance_s = 1'b0;
                    end
                end else if (active_q && (remain_s != {RW{1'b0}}) && fifo_rd_vld) begin
                    state_d   = AW;
                    awvalid_d = 1'b1;
                    awaddr_d  = addr_s;
                    awlen_d   = next_len_s;
                end else begin
                    state_d = IDLE;
                end
            end
            AW: begin
                if (frame_start) begin
                    start_pend_d = 1'b1;
                    overrun_d    = 1'b1;
                end else begin
                    start_pend_d = start_pend_q;
                end
                if (awready) begin
                    awvalid_d  = 1'b0;
                    beat_cnt_d = 8'd0;
                    state_d    = W;
                end else begin
                    state_d = AW;
                end
            end
            W: begin
                if (frame_start) begin
                    start_pend_d = 1'b1;
                    overrun_d    = 1'b1;
                end else begin
                    start_pend_d = start_pend_q;
                end
                if (beat_s) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_cnt_q == awlen_q) begin
                        state_d = B;
                    end else begin
                        state_d = W;
                    end
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            B: begin
                if (bvalid) begin
                    state_d      = IDLE;
                    start_pend_d = 1'b0;
                    burst_done_s = 1'b1;
                    if (bresp != AXI_RESP_OKAY) begin
                        bresp_err_d = 1'b1;
                    end else begin
                        bresp_err_d = bresp_err_q;
                    end
                    if (complete_s) begin
                        advance_s    = 1'b1;
                        frame_done_d = 1'b1;
                        load_s       = pend_s;
                        active_d     = pend_s;
                    end else if (pend_s) begin
                        // Drop the rest of this frame and restart on the next buffer.
                        advance_s = 1'b1;
                        load_s    = 1'b1;
                        active_d  = 1'b1;
                        overrun_d = 1'b1;
                    end else begin
                        active_d = active_q;
                    end
                end else if (frame_start) begin
                    start_pend_d = 1'b1;
                    overrun_d    = 1'b1;
                end else begin
                    state_d = B;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            active_q     <= 1'b0;
            start_pend_q <= 1'b0;
            awvalid_q    <= 1'b0;
            awaddr_q     <= {ADDR_WIDTH{1'b0}};
            awlen_q      <= 8'd0;
            beat_cnt_q   <= 8'd0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            bresp_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            start_pend_q <= start_pend_d;
            awvalid_q    <= awvalid_d;
            awaddr_q     <= awaddr_d;
            awlen_q      <= awlen_d;
            beat_cnt_q   <= beat_cnt_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            bresp_err_q  <= bresp_err_d;
        end
    end

    // W channel is a straight pass-through of the FIFO head so a beat costs no extra cycle.
    assign wvalid     = (state_q == W) && fifo_rd_vld;
    assign wdata      = fifo_rd_data;
    assign wstrb      = {BPB{1'b1}};
    assign wlast      = (state_q == W) && (beat_cnt_q == awlen_q);
    assign fifo_rd_en = (state_q == W) && wready;
    assign bready     = (state_q == B);
    assign awvalid    = awvalid_q;
    assign awaddr     = awaddr_q;
    assign awlen      = awlen_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
    assign bresp_err  = bresp_err_q;

endmodule

// File: tb/tb_vid_ddr_wr_burst.sv
// Directed bench: 40-beat frames in 16-beat bursts over a 3-buffer ring, with a FIFO and AXI slave model.
module tb_vid_ddr_wr_burst;

    localparam int DW  = 256;
    localparam int AWD = 28;
    localparam int BPB = DW / 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           frame_start = 1'b0;
    logic [DW-1:0]  fifo_rd_data = '0;
    logic           fifo_rd_vld = 1'b0;
    logic           fifo_rd_en;
    logic [AWD-1:0] awaddr;
    logic [7:0]     awlen;
    logic           awvalid;
    logic           awready = 1'b0;
    logic [DW-1:0]  wdata;
    logic [BPB-1:0] wstrb;
    logic           wlast;
    logic           wvalid;
    logic           wready = 1'b0;
    logic [1:0]     bresp = 2'b00;
    logic           bvalid = 1'b0;
    logic           bready;
    logic           frame_done;
    logic [2:0]     cur_buf;
    logic           overrun;
    logic           bresp_err;

    always #5 clk = ~clk;

    vid_ddr_wr_burst #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AWD),
        .BURST_LEN  (16),
        .FRAME_BEATS(40),
        .NUM_BUF    (3),
        .BASE_ADDR  (32'h0000_0000),
        .BUF_STRIDE (32'h0100_0000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_en(fifo_rd_en),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .frame_done(frame_done), .cur_buf(cur_buf), .overrun(overrun), .bresp_err(bresp_err)
    );

    int checks = 0;
    int failures = 0;

    logic [DW-1:0]  fifo_q[$];
    logic [DW-1:0]  exp_q[$];
    logic [DW-1:0]  beat_log[$];
    logic [AWD-1:0] aw_addr_log[$];
    logic [7:0]     aw_len_log[$];
    int             last_log[$];

    int cyc = 0, pops = 0, beats = 0, aw_count = 0, frame_dones = 0;
    int stall_viol = 0, bh_cycle = 0, fd_cycle = 0, err_burst = -1;
    bit fs_req = 0, rst_req = 0, gap_en = 0, wr_rand = 0, aw_rand = 0, b_pend = 0, aw_hold = 0;
    logic [1:0]     b_code = 2'b00;
    logic [AWD-1:0] hold_addr = '0;
    logic [7:0]     hold_len = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock: drive at negedge, observe handshakes 1 ns before the rising edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        rst_n = !rst_req;
        if (rst_req) begin
            b_pend  = 0;
            aw_hold = 0;
        end
        rst_req = 0;
        frame_start  = fs_req;
        fs_req       = 0;
        fifo_rd_vld  = (fifo_q.size() > 0) && !(gap_en && ($urandom_range(0, 3) == 0));
        fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        wready       = wr_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        awready      = aw_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
        bvalid       = b_pend;
        bresp        = b_code;
        #4;
        if (rst_n) begin
            if (aw_hold && (awvalid !== 1'b1 || awaddr !== hold_addr || awlen !== hold_len))
                stall_viol++;
            aw_hold   = awvalid && !awready;
            hold_addr = awaddr;
            hold_len  = awlen;
            if (awvalid && awready) begin
                aw_addr_log.push_back(awaddr);
                aw_len_log.push_back(awlen);
                aw_count++;
            end
            if (bvalid && bready) begin
                b_pend   = 0;
                bh_cycle = cyc;
            end
            if (wvalid && wready) begin
                beat_log.push_back(wdata);
                beats++;
                if (wlast) begin
                    last_log.push_back(beats);
                    b_pend = 1;
                    b_code = (aw_count == err_burst) ? 2'b10 : 2'b00;
                end
            end
            if (fifo_rd_en && fifo_rd_vld) begin
                pops++;
                void'(fifo_q.pop_front());
            end
            if (frame_done) begin
                frame_dones++;
                fd_cycle = cyc;
            end
        end
    endtask

    task automatic load_words(input int f, input int n);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = {8{16'(f), 16'(i)}};
            fifo_q.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    task automatic clear_logs();
        exp_q.delete();
        beat_log.delete();
        aw_addr_log.delete();
        aw_len_log.delete();
        last_log.delete();
        beats = 0;
        pops  = 0;
    endtask

    task automatic run_frame(input string tag);
        int target;
        target = frame_dones + 1;
        fs_req = 1;
        for (int k = 0; k < 3000 && frame_dones < target; k++) step();
        chk({tag, "_timeout"}, 64'(frame_dones < target), 64'd0);
    endtask

    task automatic check_data(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= beat_log.size() || beat_log[i] !== exp_q[i]) bad++;
        chk({tag, "_data_order"}, 64'(bad), 64'd0);
        chk({tag, "_beat_count"}, 64'(beat_log.size()), 64'(exp_q.size()));
    endtask

    function automatic logic [AWD-1:0] aw_at(input int i);
        return (i < aw_addr_log.size()) ? aw_addr_log[i] : {AWD{1'b1}};
    endfunction

    function automatic logic [7:0] len_at(input int i);
        return (i < aw_len_log.size()) ? aw_len_log[i] : 8'hxx;
    endfunction

    function automatic int last_at(input int i);
        return (i < last_log.size()) ? last_log[i] : -1;
    endfunction

    initial begin
        int fd_before, aw_before, pops_before;

        for (int i = 0; i < 3; i++) begin
            rst_req = 1;
            step();
        end
        step();
        chk("rst_awvalid", 64'(awvalid), 64'd0);
        chk("rst_awaddr", 64'(awaddr), 64'd0);
        chk("rst_awlen", 64'(awlen), 64'd0);
        chk("rst_wvalid", 64'(wvalid), 64'd0);
        chk("rst_bready", 64'(bready), 64'd0);
        chk("rst_flags", 64'({frame_done, overrun, bresp_err, cur_buf}), 64'd0);
        chk("wstrb_ones", 64'(&wstrb), 64'd1);

        // Data waiting but no frame_start yet: nothing may move.
        clear_logs();
        load_words(1, 40);
        for (int i = 0; i < 6; i++) step();
        chk("idle_no_pop", 64'(pops), 64'd0);
        chk("idle_no_aw", 64'(aw_count), 64'd0);

        // Frame 1, buffer 0: bursts at 0x000/0x200/0x400 of 16/16/8 beats.
        run_frame("f1");
        chk("f1_aw0", 64'(aw_at(0)), 64'h000);
        chk("f1_aw1", 64'(aw_at(1)), 64'h200);
        chk("f1_aw2", 64'(aw_at(2)), 64'h400);
        chk("f1_len0", 64'(len_at(0)), 64'd15);
        chk("f1_len2", 64'(len_at(2)), 64'd7);
        chk("f1_wlast0", 64'(last_at(0)), 64'd16);
        chk("f1_wlast1", 64'(last_at(1)), 64'd32);
        chk("f1_wlast2", 64'(last_at(2)), 64'd40);
        chk("f1_nlast", 64'(last_log.size()), 64'd3);
        check_data("f1");
        chk("f1_done_lat", 64'(fd_cycle - bh_cycle), 64'd1);
        chk("f1_cur_buf", 64'(cur_buf), 64'd1);

        // Frame 2, buffer 1, with backpressure everywhere and an error response on its first burst.
        clear_logs();
        load_words(2, 40);
        gap_en = 1; wr_rand = 1; aw_rand = 1;
        err_burst = aw_count + 1;
        run_frame("f2");
        gap_en = 0; wr_rand = 0; aw_rand = 0;
        chk("f2_aw0", 64'(aw_at(0)), 64'h100_0000);
        chk("f2_aw1", 64'(aw_at(1)), 64'h100_0200);
        chk("f2_aw2", 64'(aw_at(2)), 64'h100_0400);
        check_data("f2");
        chk("f2_pops_eq_beats", 64'(pops), 64'(beats));
        chk("f2_aw_stable", 64'(stall_viol), 64'd0);
        chk("f2_bresp_err", 64'(bresp_err), 64'd1);
        chk("f2_cur_buf", 64'(cur_buf), 64'd2);

        // Frame 3, buffer 2.
        clear_logs();
        load_words(3, 40);
        run_frame("f3");
        chk("f3_aw0", 64'(aw_at(0)), 64'h200_0000);
        chk("f3_bresp_err_sticky", 64'(bresp_err), 64'd1);
        chk("f3_no_overrun", 64'(overrun), 64'd0);
        chk("f3_cur_buf", 64'(cur_buf), 64'd0);

        // Frame 4 wraps to buffer 0; a second frame_start lands during its 2nd burst.
        clear_logs();
        load_words(4, 40);
        fd_before = frame_dones;
        fs_req = 1;
        for (int k = 0; k < 300 && aw_addr_log.size() < 2; k++) step();
        for (int k = 0; k < 3; k++) step();
        fs_req = 1;
        for (int k = 0; k < 300 && aw_addr_log.size() < 3; k++) step();
        chk("f4_aw0_wrap", 64'(aw_at(0)), 64'h000);
        chk("f4_aw1", 64'(aw_at(1)), 64'h200);
        chk("ovr_burst_completed", 64'(beats), 64'd32);
        chk("ovr_next_aw", 64'(aw_at(2)), 64'h100_0000);
        chk("ovr_next_len", 64'(len_at(2)), 64'd15);
        chk("ovr_flag", 64'(overrun), 64'd1);
        chk("ovr_cur_buf", 64'(cur_buf), 64'd1);
        chk("ovr_no_done", 64'(frame_dones), 64'(fd_before));

        // The restarted frame drains the last 8 words then starves mid-W; reset it there.
        for (int k = 0; k < 100 && beats < 40; k++) step();
        step();
        chk("pre_rst_in_w", 64'(fifo_rd_en), 64'd1);
        rst_req = 1;
        step();
        step();
        chk("mid_rst_awvalid", 64'(awvalid), 64'd0);
        chk("mid_rst_w", 64'({wvalid, wlast, fifo_rd_en, bready}), 64'd0);
        chk("mid_rst_flags", 64'({frame_done, overrun, bresp_err, cur_buf}), 64'd0);
        chk("mid_rst_aw", 64'({awaddr, awlen}), 64'd0);
        fifo_q.delete();
        clear_logs();
        load_words(5, 8);
        aw_before = aw_count;
        pops_before = pops;
        for (int k = 0; k < 20; k++) step();
        chk("post_rst_no_aw", 64'(aw_count), 64'(aw_before));
        chk("post_rst_no_pop", 64'(pops), 64'(pops_before));

        // A fresh frame after reset starts again from buffer 0.
        fifo_q.delete();
        clear_logs();
        load_words(6, 40);
        run_frame("f6");
        chk("f6_aw0", 64'(aw_at(0)), 64'h000);
        check_data("f6");
        chk("f6_cur_buf", 64'(cur_buf), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
